avn_sram_ctrl: RTL and testbench
================================

AVN_SRAM_CTRL -- requirements
Module: avn_sram_ctrl

Interface
REQ-001 SHALL have parameter SRAM_AW, default 18, meaning SRAM halfword-address width.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, range 1..15, meaning cycles per halfword phase in which the strobe is active.
REQ-003 SHALL have ports: clk  input  1  clock. One clock; reset is asynchronous and active-high.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 avn_req  input  avalon_req_t  Avalon-MM request: read, write, address, byte_enable, writedata.
REQ-006 avn_resp  output  avalon_resp_t  Avalon-MM response: waitrequest, readdata.
REQ-007 sram_addr  output  SRAM_AW  halfword address.
REQ-008 sram_dq_out  output  16  write data.
REQ-009 sram_dq_oe  output  1  data driver enable; the tristate lives at top level.
REQ-010 sram_dq_in  input  16  read data.
REQ-011 sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  output  1 each  active-low SRAM strobes.

Function
REQ-012 SHALL act as the Avalon responder: a request stays stable while waitrequest=1 and is accepted in the cycle with (read|write)&~waitrequest.
REQ-013 SHALL present readdata valid in the cycle after read acceptance and hold it until the next read capture.
REQ-014 waitrequest SHALL be 1 whenever read|write=1 and state!=ACK, and 0 otherwise; with no request, waitrequest=0.
REQ-015 States SHALL be IDLE, LO, HI, ACK.
REQ-016 IDLE transitions: on request, go to LO if byte_enable[1:0]!=0; else go to HI if byte_enable[3:2]!=0; else go to ACK.
REQ-017 LO and HI phases SHALL each last WAIT_CYCLES+1 cycles, timed by a 4-bit counter cleared on phase entry.
REQ-018 LO transitions: go to HI if byte_enable[3:2]!=0, else go to ACK.
REQ-019 HI transition: go to ACK.
REQ-020 ACK SHALL last one cycle with waitrequest=0, then go to IDLE.
REQ-021 sram_addr SHALL be {address[SRAM_AW:2], phase}, where phase is 0 for LO and 1 for HI.
REQ-022 sram_ub_n and sram_lb_n SHALL be the inverted byte_enable bits of the active halfword.
REQ-023 Strobe timing: sram_ce_n=0 during the LO and HI phases; for reads sram_oe_n=0 for the whole phase; for writes sram_we_n=0 for the first WAIT_CYCLES cycles and 1 in the final phase cycle (address/data hold).
REQ-024 Writes SHALL drive sram_dq_oe=1 and sram_dq_out = the active writedata halfword.
REQ-025 Reads SHALL capture sram_dq_in into the matching readdata halfword on the final phase cycle.
REQ-026 Readdata bytes whose byte_enable is 0 SHALL be returned as 0.
REQ-027 A read with byte_enable=0 SHALL return 0 via ACK.
REQ-028 read&write both set: SHALL be treated as a write.
REQ-029 Back-to-back requests: the request present in the cycle after ACK SHALL start from IDLE; minimum spacing is one IDLE cycle.
REQ-030 All SRAM strobes and sram_dq_oe SHALL be driven from flops (glitch-free); the strobe registers update one cycle ahead of the phase they belong to.

Reset
REQ-031 On rst: state=IDLE, counter=0, readdata=0, sram_ce_n=sram_oe_n=sram_we_n=sram_ub_n=sram_lb_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
REQ-032 waitrequest during reset SHALL equal read|write.
REQ-033 Reset mid-transfer SHALL abort with no further SRAM strobe, and the aborted request SHALL NOT be accepted.

Structure
REQ-034 avalon_req_t and avalon_resp_t SHALL come from the shared core package/header; the SRAM_AW default SHALL be a package constant.
REQ-035 state_t SHALL be local to the module.
REQ-036 Single module; no sub-module is required.

Verification
REQ-037 Full-word write (WAIT_CYCLES=1): addr 0x10, data 0xA5A5_1234, be 0xF -> halfword 8=0x1234, halfword 9=0xA5A5; waitrequest high for 5 cycles, low in cycle 6.
REQ-038 Full-word read of addr 0x10 -> readdata 0xA5A5_1234 one cycle after acceptance; the readdata value holds.
REQ-039 Byte write be=0x4, data 0x00EE_0000 -> only the HI phase runs, with ub_n=1 and lb_n=0; a subsequent read returns 0xA5EE_1234.
REQ-040 Read with be=0x0 -> accepted after 1 wait cycle, readdata=0, ce_n never asserted.
REQ-041 rst asserted in the second cycle of the LO phase of a write -> all strobes return to 1 immediately, no acceptance; after release, a re-issued write completes normally.
REQ-042 WAIT_CYCLES=3 back-to-back read then write -> each phase lasts 4 cycles, we_n low 3 cycles, and exactly one IDLE cycle separates the transactions.

Source files
------------

// File: rtl/avn_sram_ctrl_pkg.sv
// Shared Avalon-MM request/response types and SRAM controller defaults.
package avn_sram_ctrl_pkg;

    localparam int SRAM_AW_DEFAULT = 18;

    typedef struct packed {
        logic        read;
        logic        write;
        logic [31:0] address;
        logic [3:0]  byte_enable;
        logic [31:0] writedata;
    } avalon_req_t;

    typedef struct packed {
        logic        waitrequest;
        logic [31:0] readdata;
    } avalon_resp_t;

endpackage

// File: rtl/avn_sram_ctrl.sv
// Avalon-MM responder for a 16-bit asynchronous SRAM.
// Each 32-bit access is split into a low and a high halfword phase.
// Halfwords whose byte enables are all clear are skipped.
// All SRAM strobes are registered and computed from the next state, so the
// pins change one cycle before the phase they belong to.
// SRAM_AW must be at most 30 so that the unused upper address bits exist.
//
//   state | meaning
//   IDLE  | waiting for a read or write request
//   LO    | halfword 0 access (byte_enable[1:0])
//   HI    | halfword 1 access (byte_enable[3:2])
//   ACK   | waitrequest released, request accepted this cycle
module avn_sram_ctrl
    import avn_sram_ctrl_pkg::*;
#(
    parameter int SRAM_AW     = SRAM_AW_DEFAULT,
    parameter int WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  avalon_req_t        avn_req,
    output avalon_resp_t       avn_resp,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    typedef enum logic [1:0] {IDLE, LO, HI, ACK} state_t;

    localparam logic [3:0] WC_LAST = 4'(WAIT_CYCLES);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [15:0]        dq_out_q, dq_out_d;
    logic               dq_oe_q, dq_oe_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic               ub_n_q, ub_n_d;
    logic               lb_n_q, lb_n_d;

    logic       req_any, is_wr, is_rd, be_lo, be_hi, phase_end;
    logic       in_phase_d, hi_d;
    logic [1:0] be_half_d;
    logic       unused_addr;

    // Simultaneous read and write is handled as a write.
    assign req_any   = avn_req.read | avn_req.write;
    assign is_wr     = avn_req.write;
    assign is_rd     = avn_req.read & ~avn_req.write;
    assign be_lo     = |avn_req.byte_enable[1:0];
    assign be_hi     = |avn_req.byte_enable[3:2];
    assign phase_end = (cnt_q == WC_LAST);

    assign unused_addr = ^{avn_req.address[1:0], avn_req.address[31:SRAM_AW+1]};

    assign avn_resp.waitrequest = req_any & (state_q != ACK);
    assign avn_resp.readdata    = rdata_q;

    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_ub_n   = ub_n_q;
    assign sram_lb_n   = lb_n_q;

    // Next state and phase counter; the counter restarts at every phase entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    cnt_d = 4'd0;
                    if (be_lo)      state_d = LO;
                    else if (be_hi) state_d = HI;
                    else            state_d = ACK;
                end
            end
            LO: begin
                if (phase_end) begin
                    cnt_d   = 4'd0;
                    state_d = be_hi ? HI : ACK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HI: begin
                if (phase_end) begin
                    cnt_d   = 4'd0;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // SRAM pin values for the coming cycle; we_n releases on the last phase cycle for hold.
    always_comb begin
        in_phase_d = (state_d == LO) || (state_d == HI);
        hi_d       = (state_d == HI);
        be_half_d  = hi_d ? avn_req.byte_enable[3:2] : avn_req.byte_enable[1:0];
        ce_n_d     = ~in_phase_d;
        oe_n_d     = ~(in_phase_d & is_rd);
        we_n_d     = ~(in_phase_d & is_wr & (cnt_d != WC_LAST));
        ub_n_d     = ~(in_phase_d & be_half_d[1]);
        lb_n_d     = ~(in_phase_d & be_half_d[0]);
        dq_oe_d    = in_phase_d & is_wr;
        addr_d     = addr_q;
        dq_out_d   = dq_out_q;
        if (in_phase_d) begin
            addr_d = {avn_req.address[SRAM_AW:2], hi_d};
        end
        if (in_phase_d && is_wr) begin
            dq_out_d = hi_d ? avn_req.writedata[31:16] : avn_req.writedata[15:0];
        end
    end

    // Read data: a new read starts from zero so skipped or disabled bytes return 0.
    always_comb begin
        rdata_d = rdata_q;
        if (state_q == IDLE && is_rd) begin
            rdata_d = '0;
        end
        if (state_q == LO && phase_end && is_rd) begin
            rdata_d[15:8] = avn_req.byte_enable[1] ? sram_dq_in[15:8] : 8'h00;
            rdata_d[7:0]  = avn_req.byte_enable[0] ? sram_dq_in[7:0]  : 8'h00;
        end
        if (state_q == HI && phase_end && is_rd) begin
            rdata_d[31:24] = avn_req.byte_enable[3] ? sram_dq_in[15:8] : 8'h00;
            rdata_d[23:16] = avn_req.byte_enable[2] ? sram_dq_in[7:0]  : 8'h00;
        end
    end

    // Register file: reset parks every strobe inactive immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            rdata_q  <= '0;
            addr_q   <= '0;
            dq_out_q <= '0;
            dq_oe_q  <= 1'b0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            ub_n_q   <= 1'b1;
            lb_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            dq_out_q <= dq_out_d;
            dq_oe_q  <= dq_oe_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            ub_n_q   <= ub_n_d;
            lb_n_q   <= lb_n_d;
        end
    end

endmodule

// File: tb/tb_avn_sram_ctrl.sv
// Directed bench: one instance with WAIT_CYCLES=1 and one with WAIT_CYCLES=3,
// each attached to a small behavioural SRAM.
module tb_avn_sram_ctrl;
    import avn_sram_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    avalon_req_t  req1, req3;
    avalon_resp_t resp1, resp3;
    logic [17:0]  addr1, addr3;
    logic [15:0]  dq_out1, dq_out3, dq_in1, dq_in3;
    logic         dq_oe1, dq_oe3;
    logic         ce_n1, oe_n1, we_n1, ub_n1, lb_n1;
    logic         ce_n3, oe_n3, we_n3, ub_n3, lb_n3;

    logic [15:0] mem1 [256];
    logic [15:0] mem3 [256];

    int tests = 0;
    int fails = 0;

    // monitor counters
    int ce_lo1, we_lo1, oe_lo1, acc1;
    logic last_ub1, last_lb1;
    int ce_lo3, we_lo3, oe_lo3, acc3, lo_cyc3, hi_cyc3;
    int we_run3, we_max3, ce_hi_run3, last_gap3;

    avn_sram_ctrl #(.SRAM_AW(18), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .avn_req(req1), .avn_resp(resp1),
        .sram_addr(addr1), .sram_dq_out(dq_out1), .sram_dq_oe(dq_oe1), .sram_dq_in(dq_in1),
        .sram_ce_n(ce_n1), .sram_oe_n(oe_n1), .sram_we_n(we_n1), .sram_ub_n(ub_n1), .sram_lb_n(lb_n1)
    );

    avn_sram_ctrl #(.SRAM_AW(18), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .avn_req(req3), .avn_resp(resp3),
        .sram_addr(addr3), .sram_dq_out(dq_out3), .sram_dq_oe(dq_oe3), .sram_dq_in(dq_in3),
        .sram_ce_n(ce_n3), .sram_oe_n(oe_n3), .sram_we_n(we_n3), .sram_ub_n(ub_n3), .sram_lb_n(lb_n3)
    );

    // asynchronous SRAM models
    assign dq_in1 = !oe_n1 ? mem1[addr1[7:0]] : 16'hDEAD;
    assign dq_in3 = !oe_n3 ? mem3[addr3[7:0]] : 16'hDEAD;

    always @(posedge clk) begin
        if (!ce_n1 && !we_n1 && dq_oe1) begin
            if (!lb_n1) mem1[addr1[7:0]][7:0]  = dq_out1[7:0];
            if (!ub_n1) mem1[addr1[7:0]][15:8] = dq_out1[15:8];
        end
        if (!ce_n3 && !we_n3 && dq_oe3) begin
            if (!lb_n3) mem3[addr3[7:0]][7:0]  = dq_out3[7:0];
            if (!ub_n3) mem3[addr3[7:0]][15:8] = dq_out3[15:8];
        end
    end

    // pin activity monitors, sampled mid-cycle
    always @(negedge clk) begin
        if (!ce_n1) begin
            ce_lo1++;
            last_ub1 = ub_n1;
            last_lb1 = lb_n1;
        end
        if (!we_n1) we_lo1++;
        if (!oe_n1) oe_lo1++;
        if ((req1.read | req1.write) && !resp1.waitrequest) acc1++;
        if (!ce_n3) begin
            ce_lo3++;
            if (addr3[0]) hi_cyc3++; else lo_cyc3++;
            if (ce_hi_run3 != 0) last_gap3 = ce_hi_run3;
            ce_hi_run3 = 0;
        end else begin
            ce_hi_run3++;
        end
        if (!we_n3) begin
            we_lo3++;
            we_run3++;
            if (we_run3 > we_max3) we_max3 = we_run3;
        end else begin
            we_run3 = 0;
        end
        if (!oe_n3) oe_lo3++;
        if ((req3.read | req3.write) && !resp3.waitrequest) acc3++;
    end

    task automatic clr_mon();
        ce_lo1 = 0; we_lo1 = 0; oe_lo1 = 0; acc1 = 0;
        ce_lo3 = 0; we_lo3 = 0; oe_lo3 = 0; acc3 = 0;
        lo_cyc3 = 0; hi_cyc3 = 0; we_max3 = 0; last_gap3 = 0;
    endtask

    task automatic drive(input int d, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        avalon_req_t r;
        r.read = rd;
        r.write = wr;
        r.address = a;
        r.byte_enable = be;
        r.writedata = wd;
        if (d == 3) req3 = r; else req1 = r;
    endtask

    // counts waitrequest-high cycles until acceptance, then drops the request
    task automatic wait_accept(input int d, output int n);
        logic wr_now;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            wr_now = (d == 3) ? resp3.waitrequest : resp1.waitrequest;
            if (!wr_now) break;
            n++;
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        drive(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic test_reset();
        tests++;
        if (resp1.waitrequest !== 1'b0) begin fails++; $display("FAIL rst_waitreq_idle: got %b want 0", resp1.waitrequest); end
        tests++;
        if (resp1.readdata !== 32'h0) begin fails++; $display("FAIL rst_readdata: got %h want 0", resp1.readdata); end
        tests++;
        if ({ce_n1, oe_n1, we_n1, ub_n1, lb_n1, dq_oe1} !== 6'b111110) begin
            fails++; $display("FAIL rst_strobes: got %b want 111110", {ce_n1, oe_n1, we_n1, ub_n1, lb_n1, dq_oe1});
        end
        tests++;
        if ({addr1, dq_out1} !== 34'h0) begin fails++; $display("FAIL rst_addr_data: got %h/%h want 0/0", addr1, dq_out1); end
        drive(1, 1'b0, 1'b1, 32'h10, 4'hF, 32'h1);
        #1;
        tests++;
        if (resp1.waitrequest !== 1'b1) begin fails++; $display("FAIL rst_waitreq_req: got %b want 1", resp1.waitrequest); end
        drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic test_full_write();
        int n;
        clr_mon();
        drive(1, 1'b0, 1'b1, 32'h10, 4'hF, 32'hA5A5_1234);
        wait_accept(1, n);
        tests++;
        if (n !== 5) begin fails++; $display("FAIL fw_wait_cycles: got %0d want 5", n); end
        tests++;
        if (mem1[8] !== 16'h1234 || mem1[9] !== 16'hA5A5) begin
            fails++; $display("FAIL fw_mem: got %h/%h want 1234/a5a5", mem1[8], mem1[9]);
        end
        tests++;
        if (ce_lo1 !== 4 || we_lo1 !== 2 || oe_lo1 !== 0 || acc1 !== 1) begin
            fails++; $display("FAIL fw_strobes: got ce%0d we%0d oe%0d acc%0d want ce4 we2 oe0 acc1", ce_lo1, we_lo1, oe_lo1, acc1);
        end
    endtask

    task automatic test_full_read();
        int n;
        clr_mon();
        drive(1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        wait_accept(1, n);
        tests++;
        if (resp1.readdata !== 32'hA5A5_1234) begin fails++; $display("FAIL fr_data: got %h want a5a51234", resp1.readdata); end
        tests++;
        if (n !== 5 || oe_lo1 !== 4 || we_lo1 !== 0) begin
            fails++; $display("FAIL fr_timing: got wait%0d oe%0d we%0d want 5 4 0", n, oe_lo1, we_lo1);
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (resp1.readdata !== 32'hA5A5_1234) begin fails++; $display("FAIL fr_hold: got %h want a5a51234", resp1.readdata); end
    endtask

    task automatic test_byte_write();
        int n;
        clr_mon();
        drive(1, 1'b0, 1'b1, 32'h10, 4'h4, 32'h00EE_0000);
        wait_accept(1, n);
        tests++;
        if (n !== 3 || ce_lo1 !== 2) begin fails++; $display("FAIL bw_hi_only: got wait%0d ce%0d want 3 2", n, ce_lo1); end
        tests++;
        if (last_ub1 !== 1'b1 || last_lb1 !== 1'b0) begin
            fails++; $display("FAIL bw_ub_lb: got ub%b lb%b want ub1 lb0", last_ub1, last_lb1);
        end
        drive(1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        wait_accept(1, n);
        tests++;
        if (resp1.readdata !== 32'hA5EE_1234) begin fails++; $display("FAIL bw_readback: got %h want a5ee1234", resp1.readdata); end
        drive(1, 1'b1, 1'b0, 32'h10, 4'h6, 32'h0);
        wait_accept(1, n);
        tests++;
        if (resp1.readdata !== 32'h00EE_1200) begin fails++; $display("FAIL bw_masked_read: got %h want 00ee1200", resp1.readdata); end
    endtask

    task automatic test_zero_be_read();
        int n;
        clr_mon();
        drive(1, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        wait_accept(1, n);
        tests++;
        if (n !== 1) begin fails++; $display("FAIL zbe_wait: got %0d want 1", n); end
        tests++;
        if (resp1.readdata !== 32'h0) begin fails++; $display("FAIL zbe_data: got %h want 0", resp1.readdata); end
        tests++;
        if (ce_lo1 !== 0 || acc1 !== 1) begin fails++; $display("FAIL zbe_ce: got ce%0d acc%0d want 0 1", ce_lo1, acc1); end
    endtask

    task automatic test_read_write_both();
        int n;
        clr_mon();
        drive(1, 1'b1, 1'b1, 32'h20, 4'hF, 32'hDEAD_BEEF);
        wait_accept(1, n);
        tests++;
        if (mem1[16] !== 16'hBEEF || mem1[17] !== 16'hDEAD) begin
            fails++; $display("FAIL rw_mem: got %h/%h want beef/dead", mem1[16], mem1[17]);
        end
        tests++;
        if (oe_lo1 !== 0 || we_lo1 !== 2) begin fails++; $display("FAIL rw_strobes: got oe%0d we%0d want 0 2", oe_lo1, we_lo1); end
    endtask

    task automatic test_reset_abort();
        int n;
        clr_mon();
        drive(1, 1'b0, 1'b1, 32'h18, 4'hF, 32'h1111_2222);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if ({ce_n1, oe_n1, we_n1, ub_n1, lb_n1, dq_oe1} !== 6'b111110) begin
            fails++; $display("FAIL abort_strobes: got %b want 111110", {ce_n1, oe_n1, we_n1, ub_n1, lb_n1, dq_oe1});
        end
        tests++;
        if (resp1.waitrequest !== 1'b1) begin fails++; $display("FAIL abort_waitreq: got %b want 1", resp1.waitrequest); end
        ce_lo1 = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_accept(1, n);
        tests++;
        if (n !== 5 || acc1 !== 1 || ce_lo1 !== 4) begin
            fails++; $display("FAIL abort_reissue: got wait%0d acc%0d ce%0d want 5 1 4", n, acc1, ce_lo1);
        end
        tests++;
        if (mem1[12] !== 16'h2222 || mem1[13] !== 16'h1111) begin
            fails++; $display("FAIL abort_mem: got %h/%h want 2222/1111", mem1[12], mem1[13]);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        clr_mon();
        drive(3, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
        wait_accept(3, n);
        tests++;
        if (resp3.readdata !== 32'h9ABC_5678) begin fails++; $display("FAIL b2b_rdata: got %h want 9abc5678", resp3.readdata); end
        tests++;
        if (n !== 9 || lo_cyc3 !== 4 || hi_cyc3 !== 4 || oe_lo3 !== 8) begin
            fails++; $display("FAIL b2b_rd_phases: got wait%0d lo%0d hi%0d oe%0d want 9 4 4 8", n, lo_cyc3, hi_cyc3, oe_lo3);
        end
        clr_mon();
        drive(3, 1'b0, 1'b1, 32'h4, 4'hF, 32'h0F0F_F0F0);
        wait_accept(3, n);
        tests++;
        if (n !== 9 || we_lo3 !== 6 || we_max3 !== 3) begin
            fails++; $display("FAIL b2b_wr_timing: got wait%0d we%0d werun%0d want 9 6 3", n, we_lo3, we_max3);
        end
        tests++;
        if (last_gap3 !== 2) begin fails++; $display("FAIL b2b_gap: got %0d ce-idle cycles want 2 (ACK+IDLE)", last_gap3); end
        tests++;
        if (mem3[2] !== 16'hF0F0 || mem3[3] !== 16'h0F0F) begin
            fails++; $display("FAIL b2b_mem: got %h/%h want f0f0/0f0f", mem3[2], mem3[3]);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem1[i] = 16'h0;
            mem3[i] = 16'h0;
        end
        mem3[0] = 16'h5678;
        mem3[1] = 16'h9ABC;
        ce_hi_run3 = 0;
        we_run3 = 0;
        clr_mon();
        rst = 1'b1;
        drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(3, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_full_write();
        test_full_read();
        test_byte_write();
        test_zero_be_read();
        test_read_write_both();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
